// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: arbiter state enum, bus widths, and a word-alignment helper.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    // Instruction fetches always go out as full aligned words.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_arb_ibuf.sv
// One-entry instruction buffer: remembers the last fetched word and its tag.
// Latency: combinational lookup; fill/invalidate take effect on the next clock.
// Backpressure: none; fill and invalidate are single-cycle strobes from the arbiter.
//
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   lookup_tag             addr[31:2] of the fetch being considered
//   hit, hit_data          tag match with a valid entry, and the buffered word
//   fill_en/tag/data       write a freshly fetched word into the entry
//   inv_en/tag             completed store; clears the entry if the tag matches
module mem_arb_ibuf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-3:0] lookup_tag,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-3:0] fill_tag,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              inv_en,
    input  logic [ADDR_W-3:0] inv_tag
);

    logic              buf_valid;
    logic [ADDR_W-3:0] buf_tag;
    logic [DATA_W-1:0] buf_word;

    assign hit      = buf_valid && (buf_tag == lookup_tag);
    assign hit_data = buf_word;

    // Fill (fetch completion) and invalidate (store completion) come from
    // different arbiter states, so they never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_word  <= '0;
        end else if (fill_en) begin
            buf_valid <= 1'b1;
            buf_tag   <= fill_tag;
            buf_word  <= fill_data;
        end else if (inv_en && (inv_tag == buf_tag)) begin
            buf_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one Avalon-MM master port.
// Latency: request in IDLE at cycle 0, bus strobe cycle 1, done pulse cycle 2; +1 per wait cycle.
// Backpressure: avm_waitrequest holds all avm_* outputs and the FSM; requests are only taken in IDLE.
//
// Ports:
//   clk, reset                       clock and asynchronous active-high reset
//   fetch_req/fetch_addr             instruction fetch request
//   data_rd/data_wr/data_addr/
//   data_wdata/data_byteen           data access request (rd+wr together = write)
//   instr_out/instr_valid            fetched word and its one-cycle pulse
//   data_rdata/data_done             load result and data completion pulse
//   mem_busy                         high while a bus transfer is in progress
//   avm_*                            Avalon-MM master, all outputs registered
// Optional: define MEM_ARB_IBUF_EN to add a one-entry instruction buffer.
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              data_rd,
    input  logic              data_wr,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [BE_W-1:0]   data_byteen,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              mem_busy,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [BE_W-1:0]   avm_byteenable,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    arb_state_t state, state_nxt;

    logic              data_req;
    logic              bus_done;
    logic              start_data;
    logic              start_fetch;
    logic              take_hit;
    logic              ibuf_hit;
    logic [DATA_W-1:0] ibuf_word;

    assign data_req = data_rd | data_wr;
    assign bus_done = (state != IDLE) && !avm_waitrequest;
    assign mem_busy = (state != IDLE);

`ifdef MEM_ARB_IBUF_EN
    mem_arb_ibuf u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .lookup_tag (fetch_addr[ADDR_W-1:2]),
        .hit        (ibuf_hit),
        .hit_data   (ibuf_word),
        .fill_en    (bus_done && (state == FETCH)),
        .fill_tag   (avm_address[ADDR_W-1:2]),
        .fill_data  (avm_readdata),
        .inv_en     (bus_done && (state == DATA) && avm_write),
        .inv_tag    (avm_address[ADDR_W-1:2])
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_word = '0;
`endif

    // Next-state and per-cycle control decisions.
    always_comb begin
        state_nxt   = state;
        start_data  = 1'b0;
        start_fetch = 1'b0;
        take_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (data_req) begin
                    start_data = 1'b1;
                    state_nxt  = DATA;
                end else if (fetch_req) begin
                    // A buffered hit is answered from IDLE without a bus cycle.
                    if (ibuf_hit) begin
                        take_hit = 1'b1;
                    end else begin
                        start_fetch = 1'b1;
                        state_nxt   = FETCH;
                    end
                end
            end
            FETCH, DATA: begin
                if (!avm_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus strobes and result registers. Strobes are loaded on the accept edge
    // and only cleared on the completion edge, so they hold through any wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            instr_out      <= '0;
            instr_valid    <= 1'b0;
            data_rdata     <= '0;
            data_done      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            data_done   <= 1'b0;

            if (start_data) begin
                avm_address    <= data_addr;
                avm_writedata  <= data_wdata;
                avm_byteenable <= data_byteen;
                avm_write      <= data_wr;
                avm_read       <= !data_wr;
            end else if (start_fetch) begin
                avm_address    <= word_align(fetch_addr);
                avm_byteenable <= '1;
                avm_read       <= 1'b1;
                avm_write      <= 1'b0;
            end else if (take_hit) begin
                instr_out   <= ibuf_word;
                instr_valid <= 1'b1;
            end

            if (bus_done) begin
                avm_read  <= 1'b0;
                avm_write <= 1'b0;
                if (state == FETCH) begin
                    instr_out   <= avm_readdata;
                    instr_valid <= 1'b1;
                end else begin
                    data_done <= 1'b1;
                    // avm_write still reflects the finishing transfer here.
                    if (!avm_write) begin
                        data_rdata <= avm_readdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic.
// Latency: n/a (testbench).
// Backpressure: random avm_waitrequest from the bench's bus responder.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        data_rd;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byteen;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_busy;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    mem_port_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .fetch_req       (fetch_req),
        .fetch_addr      (fetch_addr),
        .data_rd         (data_rd),
        .data_wr         (data_wr),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_byteen     (data_byteen),
        .instr_out       (instr_out),
        .instr_valid     (instr_valid),
        .data_rdata      (data_rdata),
        .data_done       (data_done),
        .mem_busy        (mem_busy),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level reference: the transfer in flight (if any), the last
    // results handed to the pipeline, and the buffered instruction.
    bit          m_active;
    bit          m_fetch;
    bit          m_write;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic [31:0] m_instr;
    logic [31:0] m_rdata;
    bit          m_iv;
    bit          m_dd;
    bit          b_valid;
    logic [29:0] b_tag;
    logic [31:0] b_word;

    logic [31:0] addr_pool [4] = '{32'h0000_0040, 32'h0000_0044, 32'h0000_0080, 32'h0000_1000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_fetch = 0; m_write = 0;
        m_addr = '0; m_wdata = '0; m_be = '0;
        m_instr = '0; m_rdata = '0; m_iv = 0; m_dd = 0;
        b_valid = 0; b_tag = '0; b_word = '0;
    endtask

    // One clock of the reference, using the inputs the bench is driving.
    task automatic model_step();
        bit hit;
        m_iv = 0;
        m_dd = 0;
        if (m_active) begin
            if (!avm_waitrequest) begin
                if (m_fetch) begin
                    m_instr = avm_readdata;
                    m_iv    = 1;
                    b_valid = 1;
                    b_tag   = m_addr[31:2];
                    b_word  = avm_readdata;
                end else begin
                    if (!m_write) m_rdata = avm_readdata;
                    else if (b_tag == m_addr[31:2]) b_valid = 0;
                    m_dd = 1;
                end
                m_active = 0;
            end
        end else if (data_rd || data_wr) begin
            m_active = 1; m_fetch = 0; m_write = data_wr;
            m_addr = data_addr; m_wdata = data_wdata; m_be = data_byteen;
        end else if (fetch_req) begin
`ifdef MEM_ARB_IBUF_EN
            hit = b_valid && (b_tag == fetch_addr[31:2]);
`else
            hit = 0;
`endif
            if (hit) begin
                m_iv    = 1;
                m_instr = b_word;
            end else begin
                m_active = 1; m_fetch = 1; m_write = 0;
                m_addr = {fetch_addr[31:2], 2'b00}; m_be = 4'hF;
            end
        end
    endtask

    task automatic check_all();
        chk("mem_busy",    {31'd0, mem_busy},    {31'd0, m_active});
        chk("avm_read",    {31'd0, avm_read},    {31'd0, m_active && (m_fetch || !m_write)});
        chk("avm_write",   {31'd0, avm_write},   {31'd0, m_active && !m_fetch && m_write});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_iv});
        chk("data_done",   {31'd0, data_done},   {31'd0, m_dd});
        chk("instr_out",   instr_out,  m_instr);
        chk("data_rdata",  data_rdata, m_rdata);
        if (m_active) begin
            chk("avm_address",    avm_address, m_addr);
            chk("avm_byteenable", {28'd0, avm_byteenable}, {28'd0, m_be});
            if (!m_fetch && m_write) chk("avm_writedata", avm_writedata, m_wdata);
        end
    endtask

    task automatic tick(input bit fr, input logic [31:0] fa, input bit rd, input bit wr,
                        input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                        input bit wq, input logic [31:0] rdv);
        fetch_req = fr; fetch_addr = fa;
        data_rd = rd; data_wr = wr; data_addr = da; data_wdata = wd; data_byteen = be;
        avm_waitrequest = wq; avm_readdata = rdv;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input logic [31:0] rdv);
        tick(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, rdv);
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        chk({tag, "_rd"},   {31'd0, avm_read}, 32'd0);
        chk({tag, "_addr"}, avm_address, 32'd0);
        chk({tag, "_wd"},   avm_writedata, 32'd0);
        chk({tag, "_be"},   {28'd0, avm_byteenable}, 32'd0);
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        fetch_req = 0; fetch_addr = '0; data_rd = 0; data_wr = 0;
        data_addr = '0; data_wdata = '0; data_byteen = '0;
        avm_readdata = '0; avm_waitrequest = 0; reset = 0;
        model_reset();
        #2;
        pulse_reset("rst0");
        idle(32'h0);

        // Zero-wait fetch of a misaligned address.
        tick(1, 32'h0000_0013, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("f_strobe", {31'd0, avm_read}, 32'd1);
        chk("f_addr", avm_address, 32'h0000_0010);
        chk("f_be", {28'd0, avm_byteenable}, 32'hF);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h2402_0005);
        chk("f_valid", {31'd0, instr_valid}, 32'd1);
        chk("f_instr", instr_out, 32'h2402_0005);
        idle(32'h0);
        chk("f_pulse_end", {31'd0, instr_valid}, 32'd0);

        // Simultaneous fetch and load: data wins, fetch follows.
        tick(1, 32'h0000_0200, 1, 0, 32'h0000_1000, 0, 4'hF, 0, 32'h0);
        chk("pri_addr", avm_address, 32'h0000_1000);
        chk("pri_rd", {31'd0, avm_read}, 32'd1);
        tick(1, 32'h0000_0200, 0, 0, 0, 0, 0, 0, 32'h1111_2222);
        chk("pri_done", {31'd0, data_done}, 32'd1);
        chk("pri_rdata", data_rdata, 32'h1111_2222);
        tick(1, 32'h0000_0200, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("pri_fetch_rd", {31'd0, avm_read}, 32'd1);
        chk("pri_fetch_addr", avm_address, 32'h0000_0200);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h3333_4444);
        chk("pri_fetch_iv", {31'd0, instr_valid}, 32'd1);

        // Store with three wait cycles; the request drops mid-transfer.
        tick(0, 32'h0, 0, 1, 32'h0000_0080, 32'hDEAD_BEEF, 4'b0011, 1, 32'h0);
        chk("wr_strobe0", {31'd0, avm_write}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0);
            chk("wr_strobe", {31'd0, avm_write}, 32'd1);
            chk("wr_addr", avm_address, 32'h0000_0080);
            chk("wr_data", avm_writedata, 32'hDEAD_BEEF);
            chk("wr_be", {28'd0, avm_byteenable}, 32'h3);
            chk("wr_busy", {31'd0, mem_busy}, 32'd1);
        end
        tick(0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
        chk("wr_done", {31'd0, data_done}, 32'd1);
        chk("wr_rdata_held", data_rdata, 32'h1111_2222);

        // Reset in the second wait cycle of a load.
        tick(0, 32'h0, 1, 0, 32'h0000_0300, 0, 4'hF, 1, 32'h0);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0);
        pulse_reset("rst_mid");
        for (int i = 0; i < 4; i++) begin
            idle(32'h5555_5555);
            chk("rst_no_done", {31'd0, data_done}, 32'd0);
        end

`ifdef MEM_ARB_IBUF_EN
        // Buffer hit, then invalidation by a store to the same word.
        tick(1, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'hA5A5_0040);
        tick(1, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("ib_hit_nord", {31'd0, avm_read}, 32'd0);
        chk("ib_hit_iv", {31'd0, instr_valid}, 32'd1);
        chk("ib_hit_word", instr_out, 32'hA5A5_0040);
        tick(0, 32'h0, 0, 1, 32'h0000_0040, 32'h1234_5678, 4'hF, 0, 32'h0);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0);
        tick(1, 32'h0000_0040, 0, 0, 0, 0, 0, 0, 32'h0);
        chk("ib_inv_rd", {31'd0, avm_read}, 32'd1);
        tick(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h1234_5678);
`endif

        // Random traffic against the reference.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset("rst_rand");
            end else begin
                tick($urandom_range(0, 1) == 1,
                     addr_pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)),
                     $urandom_range(0, 4) == 0,
                     $urandom_range(0, 5) == 0,
                     addr_pool[$urandom_range(0, 3)],
                     $urandom,
                     4'($urandom_range(0, 15)),
                     $urandom_range(0, 2) == 0,
                     $urandom);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, asynchronous, active-high.
REQ-002 The pipeline-side inputs SHALL be:
- fetch_req in 1: fetch requested at fetch_addr.
- fetch_addr in 32: instruction byte address.
- data_rd in 1: load access requested.
- data_wr in 1: store access requested.
- data_addr in 32: data byte address.
- data_wdata in 32: store data.
- data_byteen in 4: byte lanes for the data access.
REQ-003 The pipeline-side outputs SHALL be:
- instr_out out 32: fetched instruction.
- instr_valid out 1: one-cycle pulse; instr_out is valid.
- data_rdata out 32: load result.
- data_done out 1: one-cycle pulse; data access complete.
- mem_busy out 1: arbiter is not IDLE.
REQ-004 The bus-side ports SHALL be:
- avm_address out 32.
- avm_read out 1.
- avm_write out 1.
- avm_writedata out 32.
- avm_byteenable out 4.
- avm_readdata in 32.
- avm_waitrequest in 1.

Function
REQ-005 The FSM SHALL have exactly three states, IDLE, FETCH and DATA, with every avm_* output driven only from registers.
REQ-006 In IDLE, a data request (data_rd|data_wr) SHALL move the FSM to DATA and latch data_addr, data_wdata and data_byteen; otherwise fetch_req SHALL move it to FETCH and latch fetch_addr. Data has priority on simultaneous requests.
REQ-007 In FETCH the block SHALL assert avm_read=1 with avm_address={addr[31:2],2'b00} and avm_byteenable=4'b1111.
REQ-008 In DATA the block SHALL assert avm_write=1 when the latched request was a write, and avm_read=1 otherwise. data_rd and data_wr both high SHALL be treated as a write.
REQ-009 All avm_* outputs SHALL stay stable while avm_waitrequest=1, and the FSM SHALL remain in FETCH/DATA for as long as the wait lasts.
REQ-010 In the cycle avm_waitrequest=0 in FETCH/DATA, the block SHALL capture avm_readdata (for reads) and move to IDLE. In the following cycle it SHALL pulse instr_valid (from FETCH) or data_done (from DATA) for exactly one cycle.
REQ-011 Latency with zero wait states SHALL be: request sampled in IDLE at cycle 0, bus strobe in cycle 1, done pulse in cycle 2. Each wait cycle adds exactly 1.
REQ-012 A new request SHALL be accepted in the same IDLE cycle as a done pulse, allowing back-to-back accesses every 2 cycles.
REQ-013 A started transfer SHALL never be abandoned: dropping fetch_req or data_rd/data_wr mid-transfer does not shorten it, and its done pulse is still produced.
REQ-014 A fetch request losing arbitration SHALL be served in the IDLE cycle following the data done pulse if fetch_req is still high.
REQ-015 instr_out and data_rdata SHALL hold their last captured values until the next capture.
REQ-016 mem_busy SHALL equal (state != IDLE).

Reset
REQ-017 On reset, asynchronously:
- The FSM SHALL go to IDLE.
- avm_read, avm_write, instr_valid, data_done and mem_busy SHALL be 0.
- avm_address, avm_writedata, instr_out and data_rdata SHALL be 0.
- avm_byteenable SHALL be 4'b0000.
REQ-018 Reset during a transfer SHALL drop the strobe immediately and produce no done pulse after reset release.

Configuration
REQ-019 Macro MEM_ARB_IBUF_EN SHALL control a one-entry instruction buffer holding the tag addr[31:2], the data word and a valid bit.
REQ-020 With MEM_ARB_IBUF_EN defined, the buffer SHALL behave as follows:
- Hit: fetch_req in IDLE with no data request and a valid tag match SHALL pulse instr_valid with the buffered word in the next cycle, with no bus access and the FSM staying in IDLE.
- Fill: each completed fetch SHALL fill the buffer.
- Invalidate: a completed write whose data_addr[31:2] matches the tag SHALL clear the valid bit.
REQ-021 Without MEM_ARB_IBUF_EN, every fetch SHALL use the bus and no buffer registers SHALL exist.

Structure
REQ-022 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/FETCH/DATA) and the constants ADDR_W=32, DATA_W=32, BE_W=4.
REQ-023 The buffer SHALL be sub-module mem_arb_ibuf, instantiated only under MEM_ARB_IBUF_EN.

Verification
REQ-024 Zero-wait fetch: fetch_req=1 with fetch_addr=0x00000013 -> avm_read=1 with avm_address=0x00000010 in cycle 1; readdata=0x24020005 -> instr_valid=1 and instr_out=0x24020005 in cycle 2.
REQ-025 Simultaneous fetch and data_rd at 0x1000 -> DATA first (avm_address=0x1000); after data_done, FETCH starts in the next IDLE cycle.
REQ-026 Write with 3 wait cycles: data_wr=1, wdata=0xDEADBEEF, byteen=4'b0011 -> avm_write and all avm_* stable for 4 cycles; data_done 1 cycle after waitrequest falls; mem_busy high throughout.
REQ-027 Reset asserted during the second wait cycle of a read -> avm_read=0 the same cycle; no data_done after release; FSM in IDLE.
REQ-028 With MEM_ARB_IBUF_EN: fetch 0x40 twice -> second fetch has no avm_read and instr_valid one cycle later. After a store to 0x40, the third fetch uses the bus.
